icache: RTL and testbench
=========================

# icache

Two-way set-associative, read-only instruction cache between the pipeline's fetch stage and the memory arbiter. It serves `imemaddr` lookups from the datapath side of the datapath/cache interface and answers hits combinationally. Misses are handled by a small fill state machine that issues single-word reads to memory. Replacement uses one LRU bit per set.

## Interface
Parameters:
- `SETS`, default 8: number of sets; power of two, at least 2. Index width `IW = log2(SETS)`; tag width `30 - IW`.

Ports:
- `CLK`  in  1  sole clock, rising edge.
- `nRST`  in  1  reset, asynchronous and active-low.
- `imemREN`  in  1  datapath instruction read request.
- `imemaddr`  in  32  byte address. Bits [1:0] are ignored, index is [IW+1:2], tag is [31:IW+2].
- `imemload`  out  32  instruction word, valid when `ihit`=1.
- `ihit`  out  1  request satisfied this cycle.
- `iREN`  out  1  memory read request.
- `iaddr`  out  32  memory word address, with [1:0]=00.
- `iload`  in  32  memory read data, valid when `iwait`=0 while `iREN`=1.
- `iwait`  in  1  memory busy; a read completes in the first cycle `iREN`=1 and `iwait`=0.

## Operation
- Storage: per set and way, a valid bit, a tag and one 32-bit word; per set, one LRU bit that names the way to evict.
- Lookup (combinational, state IDLE only):
  - `hit_w = valid & (tag == imemaddr tag)` for each way.
  - `ihit = imemREN & (hit0 | hit1)`.
  - `imemload` is the data of the hit way; otherwise it is 0.
  - Both ways can never hit at once, because a fill never duplicates a tag.
- LRU update:
  - On an IDLE hit in way w, `lru[set] <= ~w` at the clock edge.
  - On a fill into way w, `lru[set] <= ~w`.
- Victim selection: way0 if invalid; else way1 if invalid; else `lru[set]`.
- FSM states IDLE and FILL.
  - IDLE, with `imemREN`=1 and no hit: latch `imemaddr[31:2]` and the victim way into `miss_addr` and `miss_way`, then go to FILL. In any other case stay in IDLE.
  - FILL: `iREN=1`, `iaddr={miss_addr,2'b00}`, `ihit=0`.
  - FILL when `iwait`=0: write `iload`, the tag and valid=1 into `miss_way` of the latched set, update LRU, return to IDLE.
  - FILL when `iwait`=1: stay in FILL.
- A fill always targets the latched address. Changes to `imemaddr` or deassertion of `imemREN` during FILL do not abort or retarget it. A redirected fetch takes a fresh lookup after the return to IDLE.
- No forwarding: the filled word is delivered by a hit in the cycle after the fill completes.
- No writes and no invalidation port. Self-modifying code is unsupported.

## Timing
- Reset values:
  - Outputs: `ihit`=0, `imemload`=0, `iREN`=0, `iaddr`=0.
  - Internal: state IDLE, all valid bits 0, all LRU bits 0.
  - Tag and data arrays need not be reset.
- Reset asserted during FILL: return to IDLE immediately and drop `iREN` asynchronously. The partially fetched word is not written.
- Hit latency is 0 cycles (same cycle as the request).
- Miss latency:
  - Cycle 0: miss detected.
  - Cycles 1 through k: FILL, where k is the first cycle with `iwait`=0.
  - Cycle k+1: IDLE hit.
  - Minimum total: 2 cycles after the miss cycle.
- `iREN` and `iaddr` are functions of registered state only, with no combinational path from `imemaddr`.
- `imemREN`=0 in IDLE: `ihit`=0, no state change, no LRU update.

## Test plan
- Reset: hold `nRST`=0 and drive `imemREN`=1 at 0x0. Require `ihit`=0 and `iREN`=0. After release, a lookup at 0x0 misses.
- Cold miss, then hit: request 0x00000040. Memory holds `iwait`=1 for 2 cycles, then returns 0xDEADBEEF.
  - Require `iREN`=1 with `iaddr`=0x40 for 3 cycles.
  - In the next cycle, require `ihit`=1 and `imemload`=0xDEADBEEF.
- Conflict and LRU (`SETS`=8): fill 0x00, 0x20 and 0x40, all at set 0. Then re-read 0x20, and fill 0x60.
  - After the 0x40 fill, 0x00 misses and 0x20 hits.
  - After re-reading 0x20 and filling 0x60, 0x40 misses and 0x20 hits.
- Redirect during FILL: miss at 0x100. On the second FILL cycle, change `imemaddr` to 0x200.
  - Require `iaddr` to stay 0x100 until `iwait`=0.
  - Then 0x200 misses and fills, and 0x100 hits.
- Reset mid-fill: assert `nRST`=0 during FILL at 0x80.
  - Require `iREN`=0 immediately.
  - After release, 0x80 misses again.
- Idle request: `imemREN`=0 at a cached address. Require `ihit`=0, `iREN`=0 and no LRU change, checked by the next victim choice.

Source files
------------

// File: rtl/icache.sv
// Two-way set-associative, read-only instruction cache with one LRU bit per set.
// Hits are answered combinationally in IDLE; misses run a single-word fill from memory.
module icache #(
  parameter int SETS = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic [31:0] imemload,
  output logic        ihit,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic [31:0] iload,
  input  logic        iwait
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - IW;

  typedef enum logic {IDLE, FILL} state_t;

  state_t state, next_state;

  logic [29:0]     miss_addr;
  logic            miss_way;
  logic [SETS-1:0] valid0, valid1, lru;
  logic [TW-1:0]   tag0 [SETS];
  logic [TW-1:0]   tag1 [SETS];
  logic [31:0]     data0 [SETS];
  logic [31:0]     data1 [SETS];

  logic [IW-1:0] set_idx, miss_set;
  logic [TW-1:0] req_tag, miss_tag;
  logic          hit0, hit1, victim, fill_we, miss_start;
  logic          unused_ok;

  // Byte offset is irrelevant to a word-wide cache.
  assign unused_ok = &{1'b0, imemaddr[1:0]};

  assign set_idx  = imemaddr[IW+1:2];
  assign req_tag  = imemaddr[31:IW+2];
  assign miss_set = miss_addr[IW-1:0];
  assign miss_tag = miss_addr[29:IW];

  assign hit0 = valid0[set_idx] && (tag0[set_idx] == req_tag);
  assign hit1 = valid1[set_idx] && (tag1[set_idx] == req_tag);

  // Fill empty ways first, then fall back to the LRU bit.
  assign victim = !valid0[set_idx] ? 1'b0 :
                  !valid1[set_idx] ? 1'b1 : lru[set_idx];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    ihit       = 1'b0;
    imemload   = 32'h0;
    iREN       = 1'b0;
    iaddr      = 32'h0;
    fill_we    = 1'b0;
    miss_start = 1'b0;
    case (state)
      IDLE: begin
        if (imemREN) begin
          if (hit0 || hit1) begin
            ihit     = 1'b1;
            imemload = hit0 ? data0[set_idx] : data1[set_idx];
          end else begin
            miss_start = 1'b1;
            next_state = FILL;
          end
        end
      end
      FILL: begin
        // Driven only from latched state so memory never sees imemaddr changes.
        iREN  = 1'b1;
        iaddr = {miss_addr, 2'b00};
        if (!iwait) begin
          fill_we    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      miss_addr <= '0;
      miss_way  <= 1'b0;
      valid0    <= '0;
      valid1    <= '0;
      lru       <= '0;
    end else begin
      if (miss_start) begin
        miss_addr <= imemaddr[31:2];
        miss_way  <= victim;
      end
      if (fill_we) begin
        if (miss_way) valid1[miss_set] <= 1'b1;
        else          valid0[miss_set] <= 1'b1;
        lru[miss_set] <= ~miss_way;
      end else if (ihit) begin
        lru[set_idx] <= ~hit1;
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits guard them.
  always_ff @(posedge CLK) begin
    if (fill_we) begin
      if (miss_way) begin
        tag1[miss_set]  <= miss_tag;
        data1[miss_set] <= iload;
      end else begin
        tag0[miss_set]  <= miss_tag;
        data0[miss_set] <= iload;
      end
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: reset, cold miss, LRU conflicts, redirect,
// reset mid-fill, idle requests and back-to-back hits over all sets.
module tb_icache;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] imemload;
  logic        ihit;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];

  icache #(.SETS(8)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .imemload (imemload),
    .ihit     (ihit),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iload    (iload),
    .iwait    (iwait)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  // One IDLE-cycle lookup. keep=0 drops imemREN before the clock edge so the
  // lookup is a side-effect-free probe; keep=1 lets the edge act on it.
  task automatic access(input logic [31:0] a, input logic exp_hit,
                        input logic [31:0] exp_word, input logic keep,
                        input string name);
    logic [31:0] w;
    @(negedge CLK);
    imemREN  = 1'b1;
    imemaddr = a;
    iwait    = 1'b1;
    #1;
    checks++;
    if (ihit !== exp_hit || iREN !== 1'b0) begin
      failures++;
      $display("FAIL %s: addr=%h ihit=%b iREN=%b, want ihit=%b iREN=0",
               name, a, ihit, iREN, exp_hit);
    end
    if (exp_hit) exp_q.push_back(exp_word);
    if (ihit === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL %s: unexpected hit addr=%h data=%h", name, a, imemload);
      end else begin
        w = exp_q.pop_front();
        if (imemload !== w) begin
          failures++;
          $display("FAIL %s: addr=%h imemload=%h want=%h", name, a, imemload, w);
        end
      end
    end else begin
      if (exp_hit) w = exp_q.pop_front();
      checks++;
      if (imemload !== 32'h0) begin
        failures++;
        $display("FAIL %s: imemload=%h on no hit, want 0", name, imemload);
      end
    end
    if (!keep) imemREN = 1'b0;
  endtask

  // Serve a fill already in progress: nwait busy cycles, then the data cycle.
  task automatic fill(input logic [31:0] a, input int nwait,
                      input logic [31:0] word, input string name);
    for (int i = 0; i <= nwait; i++) begin
      @(negedge CLK);
      imemREN = 1'b0;
      iwait   = (i < nwait);
      iload   = word;
      #1;
      checks++;
      if (iREN !== 1'b1 || iaddr !== a || ihit !== 1'b0) begin
        failures++;
        $display("FAIL %s: fill cycle %0d iREN=%b iaddr=%h ihit=%b, want iREN=1 iaddr=%h ihit=0",
                 name, i, iREN, iaddr, ihit, a);
      end
    end
  endtask

  task automatic miss_fill(input logic [31:0] a, input int nwait,
                           input logic [31:0] word, input string name);
    access(a, 1'b0, 32'h0, 1'b1, name);
    fill(a, nwait, word, name);
  endtask

  task automatic apply_reset;
    @(negedge CLK);
    nRST    = 1'b0;
    imemREN = 1'b0;
    iwait   = 1'b1;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_reset;
    nRST     = 1'b0;
    imemREN  = 1'b1;
    imemaddr = 32'h0;
    iwait    = 1'b1;
    iload    = 32'h0;
    repeat (3) @(negedge CLK);
    #1;
    checks++;
    if (ihit !== 1'b0 || iREN !== 1'b0 || iaddr !== 32'h0 || imemload !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: ihit=%b iREN=%b iaddr=%h imemload=%h, want all 0",
               ihit, iREN, iaddr, imemload);
    end
    nRST    = 1'b1;
    imemREN = 1'b0;
    access(32'h0, 1'b0, 32'h0, 1'b0, "reset_cold_miss");
  endtask

  task automatic test_cold_miss;
    miss_fill(32'h40, 2, 32'hDEAD_BEEF, "cold_miss");
    access(32'h40, 1'b1, 32'hDEAD_BEEF, 1'b1, "cold_hit");
    @(negedge CLK);
    imemREN = 1'b0;
  endtask

  task automatic test_conflict_lru;
    apply_reset();
    miss_fill(32'h00, 0, word_of(32'h00), "lru_fill_00");
    miss_fill(32'h20, 1, word_of(32'h20), "lru_fill_20");
    miss_fill(32'h40, 0, word_of(32'h40), "lru_fill_40");
    access(32'h00, 1'b0, 32'h0, 1'b0, "lru_00_evicted");
    access(32'h20, 1'b1, word_of(32'h20), 1'b0, "lru_20_kept");
    access(32'h40, 1'b1, word_of(32'h40), 1'b0, "lru_40_present");
    access(32'h20, 1'b1, word_of(32'h20), 1'b1, "lru_reread_20");
    miss_fill(32'h60, 2, word_of(32'h60), "lru_fill_60");
    access(32'h40, 1'b0, 32'h0, 1'b0, "lru_40_evicted");
    access(32'h20, 1'b1, word_of(32'h20), 1'b0, "lru_20_survives");
    access(32'h60, 1'b1, word_of(32'h60), 1'b0, "lru_60_present");
  endtask

  task automatic test_redirect;
    access(32'h100, 1'b0, 32'h0, 1'b1, "redirect_miss");
    for (int i = 0; i <= 3; i++) begin
      @(negedge CLK);
      imemREN = 1'b1;
      if (i >= 1) imemaddr = 32'h200;
      iwait = (i < 3);
      iload = word_of(32'h100);
      #1;
      checks++;
      if (iREN !== 1'b1 || iaddr !== 32'h100 || ihit !== 1'b0) begin
        failures++;
        $display("FAIL redirect_hold: cycle %0d iREN=%b iaddr=%h ihit=%b, want iREN=1 iaddr=00000100 ihit=0",
                 i, iREN, iaddr, ihit);
      end
    end
    miss_fill(32'h200, 1, word_of(32'h200), "redirect_new_miss");
    access(32'h100, 1'b1, word_of(32'h100), 1'b1, "redirect_old_hit");
    access(32'h200, 1'b1, word_of(32'h200), 1'b1, "redirect_new_hit");
  endtask

  task automatic test_reset_mid_fill;
    access(32'h80, 1'b0, 32'h0, 1'b1, "rmf_miss");
    @(negedge CLK);
    imemREN = 1'b0;
    iwait   = 1'b1;
    iload   = word_of(32'h80);
    #1;
    checks++;
    if (iREN !== 1'b1 || iaddr !== 32'h80) begin
      failures++;
      $display("FAIL rmf_filling: iREN=%b iaddr=%h, want iREN=1 iaddr=00000080", iREN, iaddr);
    end
    @(negedge CLK);
    iwait = 1'b0;
    nRST  = 1'b0;
    #1;
    checks++;
    if (iREN !== 1'b0 || iaddr !== 32'h0 || ihit !== 1'b0) begin
      failures++;
      $display("FAIL rmf_async_drop: iREN=%b iaddr=%h ihit=%b, want all 0", iREN, iaddr, ihit);
    end
    @(negedge CLK);
    nRST  = 1'b1;
    iwait = 1'b1;
    access(32'h80, 1'b0, 32'h0, 1'b0, "rmf_80_not_written");
    access(32'h100, 1'b0, 32'h0, 1'b0, "rmf_valid_cleared");
  endtask

  task automatic test_idle_request;
    apply_reset();
    miss_fill(32'h00, 0, word_of(32'h00), "idle_fill_00");
    miss_fill(32'h20, 0, word_of(32'h20), "idle_fill_20");
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      imemREN  = 1'b0;
      imemaddr = 32'h00;
      #1;
      checks++;
      if (ihit !== 1'b0 || iREN !== 1'b0 || imemload !== 32'h0) begin
        failures++;
        $display("FAIL idle_no_req: ihit=%b iREN=%b imemload=%h, want 0 0 0",
                 ihit, iREN, imemload);
      end
    end
    miss_fill(32'h40, 0, word_of(32'h40), "idle_fill_40");
    access(32'h20, 1'b1, word_of(32'h20), 1'b0, "idle_lru_unchanged");
    access(32'h00, 1'b0, 32'h0, 1'b0, "idle_00_was_victim");
  endtask

  task automatic test_back_to_back;
    logic [31:0] addrs [8];
    apply_reset();
    for (int s = 0; s < 8; s++) begin
      addrs[s] = {$urandom_range(0, 32'h01FF_FFFF), 5'b0} | (s << 2);
      miss_fill(addrs[s], $urandom_range(0, 2), word_of(addrs[s]), "b2b_fill");
    end
    for (int s = 0; s < 8; s++)
      access(addrs[s], 1'b1, word_of(addrs[s]), 1'b1, "b2b_hit");
    @(negedge CLK);
    imemREN = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_conflict_lru();
    test_redirect();
    test_reset_mid_fill();
    test_idle_request();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
